// File: rtl/fighter_state_fsm.sv
// Per-player fighter character state machine for footsies.
// Turns buttons and collision events into movement, attack, hitstun and blockstun states.
module fighter_state_fsm #(
    parameter int IS_MIRRORED = 0,
    parameter int ATK_START   = 5,
    parameter int ATK_ACTIVE  = 2,
    parameter int ATK_RECOV   = 16,
    parameter int DIR_START   = 4,
    parameter int DIR_ACTIVE  = 3,
    parameter int DIR_RECOV   = 15,
    parameter int HITSTUN     = 15,
    parameter int BLOCKSTUN   = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_attack,
    input  logic       hit_received,
    input  logic       block_received,
    output logic [3:0] state,
    output logic       attack_active,
    output logic [4:0] frame_cnt
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        BACK    = 4'd1,
        FWD     = 4'd2,
        ATK_S   = 4'd3,
        ATK_A   = 4'd4,
        ATK_R   = 4'd5,
        DIR_S   = 4'd6,
        DIR_A   = 4'd7,
        DIR_R   = 4'd8,
        HIT     = 4'd9,
        BLK     = 4'd10
    } fstate_t;

    localparam logic [4:0] L_ATK_START  = 5'(ATK_START - 1);
    localparam logic [4:0] L_ATK_ACTIVE = 5'(ATK_ACTIVE - 1);
    localparam logic [4:0] L_ATK_RECOV  = 5'(ATK_RECOV - 1);
    localparam logic [4:0] L_DIR_START  = 5'(DIR_START - 1);
    localparam logic [4:0] L_DIR_ACTIVE = 5'(DIR_ACTIVE - 1);
    localparam logic [4:0] L_DIR_RECOV  = 5'(DIR_RECOV - 1);
    localparam logic [4:0] L_HITSTUN    = 5'(HITSTUN - 1);
    localparam logic [4:0] L_BLOCKSTUN  = 5'(BLOCKSTUN - 1);

    fstate_t    state_q;
    fstate_t    state_d;
    logic [4:0] cnt_q;
    logic [4:0] cnt_d;
    logic       act_q;
    logic       hit_flag;
    logic       blk_flag;
    logic       atk_prev;

    logic       hit_evt;
    logic       blk_evt;
    logic       atk_edge;
    logic       fwd;
    logic       bwd;

    // A pulse landing on the tick cycle is folded into that tick.
    assign hit_evt  = hit_flag | hit_received;
    assign blk_evt  = blk_flag | block_received;
    assign atk_edge = btn_attack & ~atk_prev;
    assign fwd      = (IS_MIRRORED != 0) ? btn_left : btn_right;
    assign bwd      = (IS_MIRRORED != 0) ? btn_right : btn_left;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            act_q    <= 1'b0;
            hit_flag <= 1'b0;
            blk_flag <= 1'b0;
            atk_prev <= 1'b1;
        end else if (frame_tick) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            act_q    <= (state_d == ATK_A) || (state_d == DIR_A);
            hit_flag <= 1'b0;
            blk_flag <= 1'b0;
            atk_prev <= btn_attack;
        end else begin
            hit_flag <= hit_flag | hit_received;
            blk_flag <= blk_flag | block_received;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (hit_evt) begin
            state_d = HIT;
            cnt_d   = L_HITSTUN;
        end else if (blk_evt) begin
            state_d = BLK;
            cnt_d   = L_BLOCKSTUN;
        end else begin
            case (state_q)
                IDLE, BACK, FWD: begin
                    cnt_d = '0;
                    if (atk_edge && (fwd ^ bwd)) begin
                        state_d = DIR_S;
                        cnt_d   = L_DIR_START;
                    end else if (atk_edge) begin
                        state_d = ATK_S;
                        cnt_d   = L_ATK_START;
                    end else if (fwd && !bwd) begin
                        state_d = FWD;
                    end else if (bwd && !fwd) begin
                        state_d = BACK;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ATK_S, ATK_A, ATK_R,
                DIR_S, DIR_A, DIR_R,
                HIT, BLK: begin
                    if (cnt_q != 5'd0) begin
                        cnt_d = cnt_q - 5'd1;
                    end else begin
                        case (state_q)
                            ATK_S: begin
                                state_d = ATK_A;
                                cnt_d   = L_ATK_ACTIVE;
                            end
                            ATK_A: begin
                                state_d = ATK_R;
                                cnt_d   = L_ATK_RECOV;
                            end
                            DIR_S: begin
                                state_d = DIR_A;
                                cnt_d   = L_DIR_ACTIVE;
                            end
                            DIR_A: begin
                                state_d = DIR_R;
                                cnt_d   = L_DIR_RECOV;
                            end
                            default: begin
                                state_d = IDLE;
                                cnt_d   = '0;
                            end
                        endcase
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign state         = state_q;
    assign frame_cnt     = cnt_q;
    assign attack_active = act_q;

endmodule

// File: tb/tb_fighter_state_fsm.sv
// Scoreboard bench for fighter_state_fsm, normal and mirrored instances.
// A timeline-queue reference model predicts every registered output cycle.
module tb_fighter_state_fsm;

    localparam int P_ATK_START  = 5;
    localparam int P_ATK_ACTIVE = 2;
    localparam int P_ATK_RECOV  = 16;
    localparam int P_DIR_START  = 4;
    localparam int P_DIR_ACTIVE = 3;
    localparam int P_DIR_RECOV  = 15;
    localparam int P_HITSTUN    = 15;
    localparam int P_BLOCKSTUN  = 10;

    logic clk = 1'b0;
    logic rst;
    logic frame_tick;
    logic btn_left;
    logic btn_right;
    logic btn_attack;
    logic hit_received;
    logic block_received;

    logic [3:0] state0;
    logic [3:0] state1;
    logic [4:0] cnt0;
    logic [4:0] cnt1;
    logic       act0;
    logic       act1;

    always #5 clk = ~clk;

    fighter_state_fsm #(
        .IS_MIRRORED(0),
        .ATK_START(P_ATK_START), .ATK_ACTIVE(P_ATK_ACTIVE),
        .ATK_RECOV(P_ATK_RECOV), .DIR_START(P_DIR_START),
        .DIR_ACTIVE(P_DIR_ACTIVE), .DIR_RECOV(P_DIR_RECOV),
        .HITSTUN(P_HITSTUN), .BLOCKSTUN(P_BLOCKSTUN)
    ) dut0 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .btn_left(btn_left), .btn_right(btn_right),
        .btn_attack(btn_attack), .hit_received(hit_received),
        .block_received(block_received), .state(state0),
        .attack_active(act0), .frame_cnt(cnt0)
    );

    fighter_state_fsm #(
        .IS_MIRRORED(1),
        .ATK_START(P_ATK_START), .ATK_ACTIVE(P_ATK_ACTIVE),
        .ATK_RECOV(P_ATK_RECOV), .DIR_START(P_DIR_START),
        .DIR_ACTIVE(P_DIR_ACTIVE), .DIR_RECOV(P_DIR_RECOV),
        .HITSTUN(P_HITSTUN), .BLOCKSTUN(P_BLOCKSTUN)
    ) dut1 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .btn_left(btn_left), .btn_right(btn_right),
        .btn_attack(btn_attack), .hit_received(hit_received),
        .block_received(block_received), .state(state1),
        .attack_active(act1), .frame_cnt(cnt1)
    );

    typedef struct {
        int st;
        int cnt;
    } seg_t;

    typedef struct {
        int st0;
        int cnt0;
        int act0;
        int st1;
        int cnt1;
        int act1;
    } exp_t;

    // Each pending frame of a timed action is one queue entry.
    seg_t tl [2][$];
    int   disp_st [2];
    int   disp_cnt [2];
    bit   hit_pend;
    bit   blk_pend;
    bit   prev_atk;
    exp_t scoreboard [$];

    int tests = 0;
    int fails = 0;

    task automatic push_seg(int m, int st, int n);
        for (int i = n - 1; i >= 0; i--) begin
            seg_t s;
            s.st  = st;
            s.cnt = i;
            tl[m].push_back(s);
        end
    endtask

    task automatic show_front(int m);
        disp_st[m]  = tl[m][0].st;
        disp_cnt[m] = tl[m][0].cnt;
    endtask

    task automatic advance(int m, bit h, bit b, bit aedge, bit f, bit bk);
        if (h) begin
            tl[m].delete();
            push_seg(m, 9, P_HITSTUN);
            show_front(m);
        end else if (b) begin
            tl[m].delete();
            push_seg(m, 10, P_BLOCKSTUN);
            show_front(m);
        end else if (tl[m].size() > 0) begin
            seg_t dummy;
            dummy = tl[m].pop_front();
            if (tl[m].size() == 0) begin
                disp_st[m]  = 0;
                disp_cnt[m] = 0;
            end else begin
                show_front(m);
            end
        end else if (aedge) begin
            if (f != bk) begin
                push_seg(m, 6, P_DIR_START);
                push_seg(m, 7, P_DIR_ACTIVE);
                push_seg(m, 8, P_DIR_RECOV);
            end else begin
                push_seg(m, 3, P_ATK_START);
                push_seg(m, 4, P_ATK_ACTIVE);
                push_seg(m, 5, P_ATK_RECOV);
            end
            show_front(m);
        end else begin
            disp_cnt[m] = 0;
            if (f && !bk)      disp_st[m] = 2;
            else if (bk && !f) disp_st[m] = 1;
            else               disp_st[m] = 0;
        end
    endtask

    // Predicts what the coming clock edge will register.
    task automatic model_step();
        exp_t e;
        if (rst) begin
            for (int m = 0; m < 2; m++) begin
                tl[m].delete();
                disp_st[m]  = 0;
                disp_cnt[m] = 0;
            end
            hit_pend = 0;
            blk_pend = 0;
            prev_atk = 1;
        end else if (frame_tick) begin
            bit h;
            bit b;
            bit ae;
            h  = hit_pend | hit_received;
            b  = blk_pend | block_received;
            ae = btn_attack & ~prev_atk;
            advance(0, h, b, ae, btn_right, btn_left);
            advance(1, h, b, ae, btn_left, btn_right);
            hit_pend = 0;
            blk_pend = 0;
            prev_atk = btn_attack;
        end else begin
            hit_pend = hit_pend | hit_received;
            blk_pend = blk_pend | block_received;
        end
        e.st0  = disp_st[0];
        e.cnt0 = disp_cnt[0];
        e.act0 = (disp_st[0] == 4 || disp_st[0] == 7) ? 1 : 0;
        e.st1  = disp_st[1];
        e.cnt1 = disp_cnt[1];
        e.act1 = (disp_st[1] == 4 || disp_st[1] == 7) ? 1 : 0;
        scoreboard.push_back(e);
    endtask

    task automatic check(string name, int act, int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d",
                     name, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (scoreboard.size() == 0) begin
                check("scoreboard_underflow", 0, 1);
            end else begin
                e = scoreboard.pop_front();
                check("state_p1", int'(state0), e.st0);
                check("frame_cnt_p1", int'(cnt0), e.cnt0);
                check("attack_active_p1", int'(act0), e.act0);
                check("state_p2", int'(state1), e.st1);
                check("frame_cnt_p2", int'(cnt1), e.cnt1);
                check("attack_active_p2", int'(act1), e.act1);
            end
        end
    end

    task automatic cyc(bit tick);
        frame_tick = tick;
        model_step();
        @(negedge clk);
        hit_received   = 1'b0;
        block_received = 1'b0;
        rst            = 1'b0;
    endtask

    task automatic ticks(int n);
        repeat (n) begin
            cyc(1'b1);
            cyc(1'b0);
        end
    endtask

    task automatic set_btn(bit l, bit r, bit a);
        btn_left   = l;
        btn_right  = r;
        btn_attack = a;
    endtask

    initial begin : driver
        rst            = 1'b1;
        frame_tick     = 1'b0;
        hit_received   = 1'b0;
        block_received = 1'b0;
        set_btn(0, 0, 1);
        cyc(1'b0);
        rst = 1'b1;
        cyc(1'b1);
        ticks(3);
        set_btn(0, 0, 0);
        ticks(2);

        // neutral attack
        set_btn(0, 0, 1);
        ticks(25);
        set_btn(0, 0, 0);
        ticks(2);

        // directional: right for p1, backward-only for p2
        set_btn(0, 1, 0);
        ticks(1);
        set_btn(0, 1, 1);
        ticks(24);
        set_btn(1, 0, 0);
        ticks(2);
        set_btn(1, 0, 1);
        ticks(24);

        // movement, with idle cycles between ticks
        set_btn(1, 0, 0);
        ticks(2);
        repeat (4) cyc(1'b0);
        set_btn(0, 1, 0);
        repeat (3) cyc(1'b0);
        ticks(2);
        set_btn(1, 1, 0);
        ticks(2);
        set_btn(0, 0, 0);
        ticks(1);

        // counter-hit in active phase, then re-hit on tick 10
        set_btn(0, 0, 1);
        ticks(6);
        cyc(1'b0);
        hit_received = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        ticks(9);
        cyc(1'b1);
        hit_received = 1'b1;
        cyc(1'b0);
        ticks(18);
        set_btn(0, 0, 0);
        ticks(1);

        // hit and block together, pulse on the tick cycle
        hit_received   = 1'b1;
        block_received = 1'b1;
        cyc(1'b1);
        ticks(16);

        // lone block from backward
        set_btn(1, 0, 0);
        ticks(2);
        block_received = 1'b1;
        cyc(1'b0);
        ticks(12);
        set_btn(0, 0, 0);
        ticks(1);

        // reset during directional recovery with attack held
        set_btn(0, 1, 1);
        ticks(10);
        rst = 1'b1;
        cyc(1'b0);
        ticks(3);
        set_btn(0, 1, 0);
        ticks(2);
        set_btn(0, 1, 1);
        ticks(3);

        // frame_tick held high across consecutive cycles
        repeat (30) cyc(1'b1);
        set_btn(0, 0, 0);
        repeat (3) cyc(1'b1);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0)
                set_btn(1'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 49) == 0) hit_received = 1'b1;
            if ($urandom_range(0, 39) == 0) block_received = 1'b1;
            if ($urandom_range(0, 599) == 0) rst = 1'b1;
            cyc(1'($urandom_range(0, 2) == 0));
        end

        if (scoreboard.size() != 0)
            check("scoreboard_leftover", scoreboard.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
